// File: rtl/regdst_hazard_ctrl.sv
// regdst_hazard_ctrl: ID destination select, EX/MEM/WB destination pipeline, stall and forward control.
// Define REGDST_HAZARD_FORWARD_EN to build with EX operand forwarding (load-use stall only).
module regdst_hazard_ctrl (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic [1:0] RegDstSel,
   input  logic [4:0] ID_Rs,
   input  logic [4:0] ID_Rt,
   input  logic [4:0] ID_Rd,
   input  logic       ID_UsesRs,
   input  logic       ID_UsesRt,
   input  logic       ID_RegWrite,
   input  logic       ID_MemRead,
   input  logic       Flush,
   output logic       Stall,
   output logic [4:0] EX_WriteReg,
   output logic [4:0] MEM_WriteReg,
   output logic [4:0] WB_WriteReg,
   output logic       WB_RegWrite,
   output logic [1:0] ForwardA,
   output logic [1:0] ForwardB
);

   typedef enum logic [1:0] {
      DST_RT   = 2'd0,
      DST_RD   = 2'd1,
      DST_RA   = 2'd2,
      DST_NONE = 2'd3
   } dst_sel_e;

   dst_sel_e   dst_sel;
   logic [4:0] id_dest;
   logic       id_we;

   logic [4:0] ex_wr_q, ex_wr_d, ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
   logic       ex_we_q, ex_we_d, ex_mr_q, ex_mr_d;
   logic [4:0] mem_wr_q, wb_wr_q;
   logic       mem_we_q, wb_we_q;

   logic       rs_live, rt_live, hit_ex, stall_raw;

   assign dst_sel = dst_sel_e'(RegDstSel);

   always_comb begin
      id_dest = '0;
      unique case (dst_sel)
         DST_RT:   id_dest = ID_Rt;
         DST_RD:   id_dest = ID_Rd;
         DST_RA:   id_dest = 5'd31;
         DST_NONE: id_dest = '0;
         default:  id_dest = '0;
      endcase
   end

   assign id_we = ID_RegWrite && (id_dest != '0) && (dst_sel != DST_NONE);

   // Register 0 is never a real dependency, so a source of 0 is treated as unused.
   assign rs_live = ID_UsesRs && (ID_Rs != '0);
   assign rt_live = ID_UsesRt && (ID_Rt != '0);
   assign hit_ex  = ex_we_q && ((rs_live && (ID_Rs == ex_wr_q)) ||
                                (rt_live && (ID_Rt == ex_wr_q)));

`ifdef REGDST_HAZARD_FORWARD_EN
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   fwd_sel_e fwd_a, fwd_b;

   assign stall_raw = ex_mr_q && hit_ex;

   always_comb begin
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
      if (mem_we_q && (mem_wr_q != '0) && (mem_wr_q == ex_rs_q))
         fwd_a = FWD_MEM;
      else if (wb_we_q && (wb_wr_q != '0) && (wb_wr_q == ex_rs_q))
         fwd_a = FWD_WB;
      if (mem_we_q && (mem_wr_q != '0) && (mem_wr_q == ex_rt_q))
         fwd_b = FWD_MEM;
      else if (wb_we_q && (wb_wr_q != '0) && (wb_wr_q == ex_rt_q))
         fwd_b = FWD_WB;
   end

   assign ForwardA = fwd_a;
   assign ForwardB = fwd_b;
`else
   logic hit_mem;
   logic unused_ex_fields;

   // WB is excluded: the register file writes before it is read.
   assign hit_mem = mem_we_q && ((rs_live && (ID_Rs == mem_wr_q)) ||
                                 (rt_live && (ID_Rt == mem_wr_q)));
   assign stall_raw = hit_ex || hit_mem;

   assign unused_ex_fields = ^{ex_mr_q, ex_rs_q, ex_rt_q};

   assign ForwardA = '0;
   assign ForwardB = '0;
`endif

   assign Stall = stall_raw && Rst_n;

   always_comb begin
      ex_wr_d = id_dest;
      ex_we_d = id_we;
      ex_mr_d = ID_MemRead;
      ex_rs_d = ID_Rs;
      ex_rt_d = ID_Rt;
      if (stall_raw || Flush) begin
         ex_wr_d = '0;
         ex_we_d = 1'b0;
         ex_mr_d = 1'b0;
         ex_rs_d = '0;
         ex_rt_d = '0;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         ex_wr_q  <= '0;
         ex_we_q  <= 1'b0;
         ex_mr_q  <= 1'b0;
         ex_rs_q  <= '0;
         ex_rt_q  <= '0;
         mem_wr_q <= '0;
         mem_we_q <= 1'b0;
         wb_wr_q  <= '0;
         wb_we_q  <= 1'b0;
      end else begin
         ex_wr_q  <= ex_wr_d;
         ex_we_q  <= ex_we_d;
         ex_mr_q  <= ex_mr_d;
         ex_rs_q  <= ex_rs_d;
         ex_rt_q  <= ex_rt_d;
         mem_wr_q <= ex_wr_q;
         mem_we_q <= ex_we_q;
         wb_wr_q  <= mem_wr_q;
         wb_we_q  <= mem_we_q;
      end
   end

   assign EX_WriteReg  = ex_wr_q;
   assign MEM_WriteReg = mem_wr_q;
   assign WB_WriteReg  = wb_wr_q;
   assign WB_RegWrite  = wb_we_q;

endmodule

// File: tb/tb_regdst_hazard_ctrl.sv
// tb_regdst_hazard_ctrl: scenario tasks for regdst_hazard_ctrl with a queue of expected WB results.
// Expectations follow REGDST_HAZARD_FORWARD_EN when it is defined for the build.
module tb_regdst_hazard_ctrl;

   logic       Clk = 1'b0;
   logic       Rst_n;
   logic [1:0] RegDstSel;
   logic [4:0] ID_Rs, ID_Rt, ID_Rd;
   logic       ID_UsesRs, ID_UsesRt, ID_RegWrite, ID_MemRead, Flush;
   logic       Stall;
   logic [4:0] EX_WriteReg, MEM_WriteReg, WB_WriteReg;
   logic       WB_RegWrite;
   logic [1:0] ForwardA, ForwardB;

   typedef struct {
      int         cyc;
      logic [4:0] wr;
      logic       we;
   } exp_t;

   exp_t sbq[$];
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

`ifdef REGDST_HAZARD_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   regdst_hazard_ctrl dut (
      .Clk          (Clk),
      .Rst_n        (Rst_n),
      .RegDstSel    (RegDstSel),
      .ID_Rs        (ID_Rs),
      .ID_Rt        (ID_Rt),
      .ID_Rd        (ID_Rd),
      .ID_UsesRs    (ID_UsesRs),
      .ID_UsesRt    (ID_UsesRt),
      .ID_RegWrite  (ID_RegWrite),
      .ID_MemRead   (ID_MemRead),
      .Flush        (Flush),
      .Stall        (Stall),
      .EX_WriteReg  (EX_WriteReg),
      .MEM_WriteReg (MEM_WriteReg),
      .WB_WriteReg  (WB_WriteReg),
      .WB_RegWrite  (WB_RegWrite),
      .ForwardA     (ForwardA),
      .ForwardB     (ForwardB)
   );

   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge Clk);
      #1;
      cyc++;
   endtask

   task automatic drive(input logic [1:0] sel, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic urs, input logic urt,
                        input logic rw, input logic mr);
      RegDstSel   = sel;
      ID_Rs       = rs;
      ID_Rt       = rt;
      ID_Rd       = rd;
      ID_UsesRs   = urs;
      ID_UsesRt   = urt;
      ID_RegWrite = rw;
      ID_MemRead  = mr;
   endtask

   task automatic nop();
      drive(2'd3, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      Flush = 1'b0;
   endtask

   task automatic idle(input int n);
      nop();
      repeat (n) tick();
   endtask

   task automatic test_reset();
      Rst_n = 1'b0;
      nop();
      #12;
      total++;
      if (Stall !== 1'b0 || EX_WriteReg !== 5'd0 || MEM_WriteReg !== 5'd0 ||
          WB_WriteReg !== 5'd0 || WB_RegWrite !== 1'b0 || ForwardA !== 2'b00 || ForwardB !== 2'b00) begin
         bad++;
         $display("FAIL reset_state: got stall=%b ex=%0d mem=%0d wb=%0d we=%b fa=%b fb=%b expected all zero",
                  Stall, EX_WriteReg, MEM_WriteReg, WB_WriteReg, WB_RegWrite, ForwardA, ForwardB);
      end
      @(negedge Clk);
      Rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_regdst();
      logic [4:0] exp_wr [4] = '{5'd5, 5'd9, 5'd31, 5'd0};
      logic       exp_we [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      exp_t e;
      idle(3);
      sbq.delete();
      for (int c = 0; c < 8; c++) begin
         if (c < 4) begin
            drive(c[1:0], 5'd0, 5'd5, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0);
            sbq.push_back('{cyc + 3, exp_wr[c], exp_we[c]});
         end else begin
            nop();
         end
         tick();
         if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            e = sbq.pop_front();
            total++;
            if (WB_WriteReg !== e.wr || WB_RegWrite !== e.we) begin
               bad++;
               $display("FAIL regdst_wb: got wr=%0d we=%b expected wr=%0d we=%b",
                        WB_WriteReg, WB_RegWrite, e.wr, e.we);
            end
         end
      end
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL regdst_drain: got %0d pending expected 0", sbq.size());
      end
   endtask

   task automatic test_load_use();
      int n;
      idle(4);
      drive(2'd0, 5'd1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      drive(2'd1, 5'd8, 5'd2, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0);
      #1;
      n = 0;
      while (Stall === 1'b1 && n < 5) begin
         tick();
         n++;
         total++;
         if (EX_WriteReg !== 5'd0) begin
            bad++;
            $display("FAIL load_use_bubble: got ex=%0d expected 0", EX_WriteReg);
         end
      end
      total++;
      if (n != (FWD ? 1 : 2)) begin
         bad++;
         $display("FAIL load_use_stall_cycles: got %0d expected %0d", n, FWD ? 1 : 2);
      end
      tick();
      total++;
      if (ForwardA !== (FWD ? 2'b01 : 2'b00) || EX_WriteReg !== 5'd10) begin
         bad++;
         $display("FAIL load_use_fwd: got fa=%b ex=%0d expected fa=%b ex=10",
                  ForwardA, EX_WriteReg, FWD ? 2'b01 : 2'b00);
      end
   endtask

   task automatic test_add_sub();
      int n;
      idle(4);
      drive(2'd1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      drive(2'd1, 5'd3, 5'd8, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0);
      #1;
      n = 0;
      while (Stall === 1'b1 && n < 5) begin
         tick();
         n++;
      end
      total++;
      if (n != (FWD ? 0 : 2)) begin
         bad++;
         $display("FAIL add_sub_stall_cycles: got %0d expected %0d", n, FWD ? 0 : 2);
      end
      tick();
      total++;
      if (ForwardB !== (FWD ? 2'b10 : 2'b00) || ForwardA !== 2'b00 || EX_WriteReg !== 5'd11) begin
         bad++;
         $display("FAIL add_sub_fwd: got fb=%b fa=%b ex=%0d expected fb=%b fa=00 ex=11",
                  ForwardB, ForwardA, EX_WriteReg, FWD ? 2'b10 : 2'b00);
      end
   endtask

   task automatic test_mem_wb_priority();
      int n;
      idle(4);
      drive(2'd1, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      drive(2'd1, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      drive(2'd1, 5'd8, 5'd0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0);
      #1;
      n = 0;
      while (Stall === 1'b1 && n < 5) begin
         tick();
         n++;
      end
      total++;
      if (n != (FWD ? 0 : 2)) begin
         bad++;
         $display("FAIL prio_stall_cycles: got %0d expected %0d", n, FWD ? 0 : 2);
      end
      tick();
      total++;
      if (ForwardA !== (FWD ? 2'b10 : 2'b00)) begin
         bad++;
         $display("FAIL prio_fwd_a: got %b expected %b", ForwardA, FWD ? 2'b10 : 2'b00);
      end
   endtask

   task automatic test_zero_dest();
      exp_t e;
      idle(4);
      sbq.delete();
      drive(2'd1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      sbq.push_back('{cyc + 3, 5'd0, 1'b0});
      tick();
      drive(2'd1, 5'd0, 5'd0, 5'd13, 1'b1, 1'b1, 1'b1, 1'b0);
      #1;
      total++;
      if (Stall !== 1'b0) begin
         bad++;
         $display("FAIL zero_dest_stall: got %b expected 0", Stall);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         if (c == 0) begin
            nop();
            total++;
            if (ForwardA !== 2'b00 || ForwardB !== 2'b00) begin
               bad++;
               $display("FAIL zero_dest_fwd: got fa=%b fb=%b expected 00 00", ForwardA, ForwardB);
            end
         end
         if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            e = sbq.pop_front();
            total++;
            if (WB_WriteReg !== e.wr || WB_RegWrite !== e.we) begin
               bad++;
               $display("FAIL zero_dest_wb: got wr=%0d we=%b expected wr=%0d we=%b",
                        WB_WriteReg, WB_RegWrite, e.wr, e.we);
            end
         end
      end
   endtask

   task automatic test_flush_stall();
      idle(4);
      drive(2'd0, 5'd1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      drive(2'd1, 5'd8, 5'd0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0);
      Flush = 1'b1;
      #1;
      total++;
      if (Stall !== 1'b1) begin
         bad++;
         $display("FAIL flush_stall_asserted: got %b expected 1", Stall);
      end
      tick();
      total++;
      if (EX_WriteReg !== 5'd0 || MEM_WriteReg !== 5'd8) begin
         bad++;
         $display("FAIL flush_stall_pipe: got ex=%0d mem=%0d expected ex=0 mem=8", EX_WriteReg, MEM_WriteReg);
      end
      idle(4);
      drive(2'd1, 5'd0, 5'd0, 5'd14, 1'b0, 1'b0, 1'b1, 1'b0);
      Flush = 1'b1;
      tick();
      total++;
      if (EX_WriteReg !== 5'd0) begin
         bad++;
         $display("FAIL flush_only: got ex=%0d expected 0", EX_WriteReg);
      end
      Flush = 1'b0;
   endtask

   task automatic test_reset_mid_stall();
      idle(4);
      drive(2'd0, 5'd1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      drive(2'd1, 5'd8, 5'd0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0);
      #1;
      total++;
      if (Stall !== 1'b1) begin
         bad++;
         $display("FAIL rst_pre_stall: got %b expected 1", Stall);
      end
      Rst_n = 1'b0;
      #1;
      total++;
      if (Stall !== 1'b0 || EX_WriteReg !== 5'd0 || MEM_WriteReg !== 5'd0 ||
          WB_WriteReg !== 5'd0 || WB_RegWrite !== 1'b0 || ForwardA !== 2'b00 || ForwardB !== 2'b00) begin
         bad++;
         $display("FAIL rst_mid_stall: got stall=%b ex=%0d mem=%0d wb=%0d we=%b fa=%b fb=%b expected all zero",
                  Stall, EX_WriteReg, MEM_WriteReg, WB_WriteReg, WB_RegWrite, ForwardA, ForwardB);
      end
      @(negedge Clk);
      Rst_n = 1'b1;
      #1;
      total++;
      if (Stall !== 1'b0) begin
         bad++;
         $display("FAIL rst_release_stall: got %b expected 0", Stall);
      end
      tick();
      total++;
      if (EX_WriteReg !== 5'd10) begin
         bad++;
         $display("FAIL rst_resume_ex: got %0d expected 10", EX_WriteReg);
      end
      idle(4);
   endtask

   initial begin
      Flush = 1'b0;
      test_reset();
      test_regdst();
      test_load_use();
      test_add_sub();
      test_mem_wb_priority();
      test_zero_dest();
      test_flush_stall();
      test_reset_mid_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regdst_hazard_ctrl.md
REGDST_HAZARD_CTRL -- requirements
Module: regdst_hazard_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset. Ports, in order:
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  async active-low reset.
- RegDstSel  in  2  destination select: 0=Rt, 1=Rd, 2=$31, 3=no destination.
- ID_Rs, ID_Rt, ID_Rd  in  5 each  decode-stage register fields.
- ID_UsesRs, ID_UsesRt  in  1 each  decode instruction reads Rs / Rt.
- ID_RegWrite, ID_MemRead  in  1 each  decode-stage control.
- Flush  in  1  taken branch/jump; kill the decode instruction.
- Stall  out  1  hold PC and IF/ID; bubble into EX.
- EX_WriteReg, MEM_WriteReg, WB_WriteReg  out  5 each  pipelined destination.
- WB_RegWrite  out  1  register-file write enable.
- ForwardA, ForwardB  out  2 each  EX operand source: 00=regfile, 10=EX/MEM, 01=MEM/WB.

Function
REQ-002 SHALL form ID destination combinationally: Rt, Rd or 31 per RegDstSel; RegDstSel=3 gives destination 0.
REQ-003 SHALL force the effective ID write enable to 0 when the ID destination is 0 or RegDstSel=3.
REQ-004 SHALL keep EX, MEM and WB stage registers for {WriteReg, RegWrite}, plus MemRead, Rs and Rt in EX; MEM and WB advance every cycle.
REQ-005 SHALL load EX from ID on each rising edge when Stall=0 and Flush=0.
REQ-006 SHALL load a bubble into EX (WriteReg=0, RegWrite=0, MemRead=0, Rs=0, Rt=0) when Stall=1 or Flush=1, including when both are 1.
REQ-007 SHALL drive EX_WriteReg, MEM_WriteReg, WB_WriteReg and WB_RegWrite directly from stage registers, giving 3-cycle ID-to-WB latency.
REQ-008 SHALL compute Stall combinationally from ID inputs and stage registers. A source is compared only when its Uses bit is 1, and a destination of 0 never matches.
REQ-009 SHALL assume a write-first register file: a WB-stage match never causes a stall.
REQ-010 SHALL keep one stall from the same hazard only until the producer advances; Stall then deasserts with no extra cycle.

Reset
REQ-011 SHALL clear all stage registers asynchronously while Rst_n=0, so all WriteReg outputs=0, WB_RegWrite=0 and ForwardA/B=00.
REQ-012 SHALL hold Stall=0 while Rst_n=0; a stall in progress is dropped at once and its producer is discarded.
REQ-013 SHALL resume with EX loading from ID on the first rising edge after Rst_n deasserts.

Configuration
REQ-014 SHALL compile forwarding in or out with the macro REGDST_HAZARD_FORWARD_EN.
REQ-015 With REGDST_HAZARD_FORWARD_EN defined:
- Stall=1 only for load-use: EX MemRead=1, EX RegWrite=1, and EX WriteReg matches a used ID source (one stall cycle).
- ForwardA (for EX Rs) and ForwardB (for EX Rt) select 10 on a MEM match with MEM RegWrite=1, else 01 on a WB match with WB RegWrite=1, else 00.
- MEM has priority over WB; register 0 is never forwarded.
REQ-016 Without REGDST_HAZARD_FORWARD_EN:
- ForwardA/B are constant 00.
- Stall=1 when a used ID source matches EX or MEM WriteReg with that stage's RegWrite=1 (up to two stall cycles).

Verification
REQ-017 Bench SHALL cover:
- RegDstSel=0/1/2/3, Rt=5, Rd=9, RegWrite=1 -> WB_WriteReg = 5, 9, 31, 0 three cycles later; WB_RegWrite=1,1,1,0.
- lw $8 then add using Rs=8 (FORWARD_EN) -> Stall=1 for exactly one cycle; next cycle ForwardA=01; only 0x00 bubble in EX.
- add $8 then sub using Rt=8 (FORWARD_EN) -> Stall=0, ForwardB=10. Without macro: Stall=1 two cycles, ForwardB=00.
- Writes to $8 in MEM and WB both, EX Rs=8 -> ForwardA=10. Destination $0 with RegWrite=1 -> WB_RegWrite=0, no stall, no forward.
- Flush=1 and Stall=1 in the same cycle -> EX gets a bubble; the producer still advances to MEM.
- Rst_n pulsed low mid-stall -> Stall=0 and all outputs 0 immediately; normal flow on the first edge after release.
